// File: rtl/jtcop_mcu_link_if.sv
// Main-CPU side bus of the MCU protection link.
//   main_din  : 68000 write data (cpu_dout)
//   main_wr   : sec[0] write select, level
//   main_rd   : sec[1] read select, level
//   main_dout : response word (mcu_dout)
//   sec2      : level-5 interrupt request to the 68000, active high
// master = 68000 side, slave = link endpoint.
interface jtcop_mcu_link_if;
  logic [15:0] main_din;
  logic        main_wr;
  logic        main_rd;
  logic [15:0] main_dout;
  logic        sec2;

  modport master (output main_din, main_wr, main_rd, input  main_dout, sec2);
  modport slave  (input  main_din, main_wr, main_rd, output main_dout, sec2);
endinterface

// File: rtl/jtcop_mcu_link.sv
// jtcop_mcu_link: MCU-side endpoint of the 68000 <-> i8751 protection link.
// Captures 16-bit command words from the 68000 and interrupts the MCU,
// serves command bytes on MCU port 0, assembles the MCU's two-byte reply
// into a tear-free word and raises sec2 for IRQ_LEN clocks on commit.
//
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   main        : main-CPU bus (jtcop_mcu_link_if.slave)
//   mcu_p0_o    : MCU port 0 output latch (response byte)
//   mcu_p2_o    : MCU port 2 output latch (control bits)
//                 [2] stage low byte, [3] stage high byte,
//                 [5:4] command byte select, [6] commit, [7] acknowledge
//   mcu_p0_i    : MCU port 0 input pins (command byte)
//   mcu_int1n   : MCU INT1, active low
//   cmd_pend    : command not yet acknowledged
//   overrun     : sticky, a command was overwritten before acknowledge
//
// Build option: define JTCOP_MCU_SYNC_EN to add a two-flop synchronizer in
// front of the input registers of main_wr, main_rd, mcu_p0_o and mcu_p2_o
// (asynchronous MCU clock). All latencies then grow by 2 clocks.
module jtcop_mcu_link #(
  parameter int IRQ_LEN = 8
) (
  input  logic               clk,
  input  logic               rstn,
  jtcop_mcu_link_if.slave    main,
  input  logic [7:0]         mcu_p0_o,
  input  logic [7:0]         mcu_p2_o,
  output logic [7:0]         mcu_p0_i,
  output logic               mcu_int1n,
  output logic               cmd_pend,
  output logic               overrun
);

  localparam logic [7:0] CNT_RLD = 8'(IRQ_LEN - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  // ---------------------------------------------------------------------
  // Optional synchronizer stage
  // ---------------------------------------------------------------------
  logic       wr_src, rd_src;
  logic [7:0] p0_src, p2_src;

`ifdef JTCOP_MCU_SYNC_EN
  logic [1:0]      wr_sy, rd_sy;
  logic [1:0][7:0] p0_sy, p2_sy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_sy <= '0;
      rd_sy <= '0;
      p0_sy <= '0;
      p2_sy <= '0;
    end else begin
      wr_sy <= {wr_sy[0], main.main_wr};
      rd_sy <= {rd_sy[0], main.main_rd};
      p0_sy <= {p0_sy[0], mcu_p0_o};
      p2_sy <= {p2_sy[0], mcu_p2_o};
    end
  end

  assign wr_src = wr_sy[1];
  assign rd_src = rd_sy[1];
  assign p0_src = p0_sy[1];
  assign p2_src = p2_sy[1];
`else
  assign wr_src = main.main_wr;
  assign rd_src = main.main_rd;
  assign p0_src = mcu_p0_o;
  assign p2_src = mcu_p2_o;
`endif

  // ---------------------------------------------------------------------
  // Input registers and previous copies for edge detection
  // ---------------------------------------------------------------------
  logic [15:0] din_l;
  logic        wr_l, rd_l, wr_p, rd_p;
  logic [7:0]  p0_l, p2_l, p2_p;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_l <= '0;
      wr_l  <= 1'b0;
      rd_l  <= 1'b0;
      wr_p  <= 1'b0;
      rd_p  <= 1'b0;
      p0_l  <= '0;
      p2_l  <= '0;
      p2_p  <= '0;
    end else begin
      din_l <= main.main_din;
      wr_l  <= wr_src;
      rd_l  <= rd_src;
      wr_p  <= wr_l;
      rd_p  <= rd_l;
      p0_l  <= p0_src;
      p2_l  <= p2_src;
      p2_p  <= p2_l;
    end
  end

  logic       wr_rise, rd_rise, ack_fall, lo_rise, hi_rise, commit;
  logic [7:0] p2_rise, p2_fall;

  assign p2_rise  = p2_l & ~p2_p;
  assign p2_fall  = ~p2_l & p2_p;
  assign wr_rise  = wr_l & ~wr_p;
  assign rd_rise  = rd_l & ~rd_p;
  assign ack_fall = p2_fall[7];
  assign lo_rise  = p2_rise[2];
  assign hi_rise  = p2_rise[3];
  assign commit   = p2_rise[6];

  logic unused_bits;
  assign unused_bits = &{1'b0, p2_rise[7], p2_rise[5:4], p2_rise[1:0],
                         p2_fall[6:0], 1'b0};

  // ---------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------
  logic [15:0] cmd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd      <= '0;
      cmd_pend <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_rise) begin
        cmd      <= din_l;
        cmd_pend <= 1'b1;
        // An acknowledge in the same clock consumed the old command,
        // so nothing was lost.
        if (cmd_pend && !ack_fall) overrun <= 1'b1;
      end else if (ack_fall) begin
        cmd_pend <= 1'b0;
      end
    end
  end

  assign mcu_int1n = ~cmd_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcu_p0_i <= 8'hff;
    end else begin
      case (p2_l[5:4])
        2'b10:   mcu_p0_i <= cmd[7:0];
        2'b01:   mcu_p0_i <= cmd[15:8];
        default: mcu_p0_i <= 8'hff;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Response staging and commit
  // ---------------------------------------------------------------------
  logic [15:0] stage, dout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
      dout  <= '0;
    end else begin
      if (lo_rise) stage[7:0]  <= p0_l;
      if (hi_rise) stage[15:8] <= p0_l;
      // Nonblocking read: a stage write in the commit clock is not seen.
      if (commit)  dout        <= stage;
    end
  end

  assign main.main_dout = dout;

  // ---------------------------------------------------------------------
  // sec2 interrupt FSM
  // ---------------------------------------------------------------------
  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (commit) begin
      // Commit beats a read abort and reloads a running pulse gap-free.
      state_nx = HOLD;
      cnt_nx   = CNT_RLD;
    end else if (state == HOLD) begin
      if (rd_rise || cnt == 8'd0) state_nx = IDLE;
      else                        cnt_nx   = cnt - 8'd1;
    end
  end

  assign main.sec2 = (state == HOLD);

endmodule

// File: tb/tb_jtcop_mcu_link.sv
module tb_jtcop_mcu_link;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] mcu_p0_o = '0;
  logic [7:0] mcu_p2_o = '0;
  logic [7:0] mcu_p0_i;
  logic       mcu_int1n, cmd_pend, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0]  byte_q[$];
  logic [15:0] resp_q[$];

  jtcop_mcu_link_if bus ();

  jtcop_mcu_link #(.IRQ_LEN(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .main      (bus.slave),
    .mcu_p0_o  (mcu_p0_o),
    .mcu_p2_o  (mcu_p2_o),
    .mcu_p0_i  (mcu_p0_i),
    .mcu_int1n (mcu_int1n),
    .cmd_pend  (cmd_pend),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},  32'(bus.main_dout), 32'h0000);
    chk({tag, "_p0i"},   32'(mcu_p0_i),      32'hff);
    chk({tag, "_int1n"}, 32'(mcu_int1n),     32'd1);
    chk({tag, "_sec2"},  32'(bus.sec2),      32'd0);
    chk({tag, "_pend"},  32'(cmd_pend),      32'd0);
    chk({tag, "_ovr"},   32'(overrun),       32'd0);
  endtask

  // Select a command byte and compare the pin value 2 clocks later.
  task automatic rd_byte(input logic [1:0] sel, input logic [7:0] exp);
    mcu_p2_o[5:4] = sel;
    byte_q.push_back(exp);
    step(2);
    chk("p0_i", 32'(mcu_p0_i), 32'(byte_q.pop_front()));
  endtask

  // Issue a commit; sec2 must rise 2 clocks later with the queued word.
  task automatic commit_chk(input logic [15:0] exp);
    resp_q.push_back(exp);
    mcu_p2_o[6] = 1'b1;
    step(1);
    chk("sec2_lat1", 32'(bus.sec2), 32'd0);
    mcu_p2_o[6] = 1'b0;
    step(1);
    chk("sec2_rise", 32'(bus.sec2), 32'd1);
    chk("dout_commit", 32'(bus.main_dout), 32'(resp_q.pop_front()));
  endtask

  // Count remaining high clocks of sec2 (current sample already counted in n).
  task automatic count_high(inout int n);
    int guard;
    guard = 0;
    while (guard < 60) begin
      step(1);
      if (!bus.sec2) break;
      n++;
      guard++;
    end
    if (guard >= 60) chk("sec2_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.sec2 && guard < 60) begin
      step(1);
      guard++;
    end
    chk("sec2_idle", 32'(bus.sec2), 32'd0);
  endtask

  task automatic write_cmd(input logic [15:0] w);
    bus.main_din = w;
    bus.main_wr  = 1'b1;
    step(3);
    bus.main_wr  = 1'b0;
    step(1);
  endtask

  initial begin
    int n;
    bus.main_din = '0;
    bus.main_wr  = 1'b0;
    bus.main_rd  = 1'b0;

    // Reset state
    step(2);
    chk_reset_vals("in_rst");
    rstn = 1'b1;
    step(2);
    chk_reset_vals("post_rst");

    // Command delivery: wr held 10 clocks
    bus.main_din = 16'hA55A;
    bus.main_wr  = 1'b1;
    step(1);
    chk("int1n_lat1", 32'(mcu_int1n), 32'd1);
    step(1);
    chk("int1n_low", 32'(mcu_int1n), 32'd0);
    chk("pend_set", 32'(cmd_pend), 32'd1);
    step(8);
    bus.main_wr = 1'b0;
    step(1);
    chk("no_retrig_ovr", 32'(overrun), 32'd0);
    rd_byte(2'b10, 8'h5A);
    rd_byte(2'b01, 8'hA5);
    rd_byte(2'b00, 8'hff);
    rd_byte(2'b11, 8'hff);

    // Acknowledge by p2[7] falling
    mcu_p2_o[7] = 1'b1;
    step(3);
    chk("pend_before_ack", 32'(cmd_pend), 32'd1);
    mcu_p2_o[7] = 1'b0;
    step(1);
    chk("int1n_ack_lat1", 32'(mcu_int1n), 32'd0);
    step(1);
    chk("int1n_release", 32'(mcu_int1n), 32'd1);
    chk("pend_clear", 32'(cmd_pend), 32'd0);

    // Response staging
    mcu_p0_o = 8'h34; mcu_p2_o[2] = 1'b1; step(3); mcu_p2_o[2] = 1'b0;
    mcu_p0_o = 8'h12; mcu_p2_o[3] = 1'b1; step(3); mcu_p2_o[3] = 1'b0;
    step(1);
    chk("dout_pre_commit", 32'(bus.main_dout), 32'h0000);
    chk("sec2_pre_commit", 32'(bus.sec2), 32'd0);

    // Single commit: sec2 exactly IRQ_LEN clocks
    commit_chk(16'h1234);
    n = 1;
    count_high(n);
    chk("sec2_len8", 32'(n), 32'd8);

    // Second commit in the 5th high clock extends to 13
    commit_chk(16'h1234);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (bus.sec2) n++;
    end
    mcu_p2_o[6] = 1'b1;
    step(1);
    if (bus.sec2) n++;
    mcu_p2_o[6] = 1'b0;
    count_high(n);
    chk("sec2_len13", 32'(n), 32'd13);

    // Main read aborts HOLD
    commit_chk(16'h1234);
    step(2);
    bus.main_rd = 1'b1;
    step(1);
    chk("abort_lat1", 32'(bus.sec2), 32'd1);
    step(1);
    chk("abort_drop", 32'(bus.sec2), 32'd0);
    chk("abort_dout", 32'(bus.main_dout), 32'h1234);
    bus.main_rd = 1'b0;
    step(2);

    // Commit and read edge together: commit wins, full reload
    commit_chk(16'h1234);
    step(1);
    bus.main_rd = 1'b1;
    mcu_p2_o[6] = 1'b1;
    step(1);
    mcu_p2_o[6] = 1'b0;
    step(1);
    n = bus.sec2 ? 1 : 0;
    count_high(n);
    chk("commit_beats_rd", 32'(n), 32'd8);
    bus.main_rd = 1'b0;
    step(2);

    // Stage write and commit in the same clock: old stage committed
    mcu_p0_o = 8'h77;
    resp_q.push_back(16'h1234);
    mcu_p2_o[2] = 1'b1;
    mcu_p2_o[6] = 1'b1;
    step(1);
    mcu_p2_o[2] = 1'b0;
    mcu_p2_o[6] = 1'b0;
    step(1);
    chk("same_clk_sec2", 32'(bus.sec2), 32'd1);
    chk("same_clk_old", 32'(bus.main_dout), 32'(resp_q.pop_front()));
    wait_idle();
    commit_chk(16'h1277);
    wait_idle();

    // Overrun: two writes without acknowledge
    write_cmd(16'h1111);
    write_cmd(16'h2222);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_pend", 32'(cmd_pend), 32'd1);
    rd_byte(2'b10, 8'h22);
    rd_byte(2'b01, 8'h22);
    mcu_p2_o[5:4] = 2'b00;
    mcu_p2_o[7] = 1'b1; step(2);
    mcu_p2_o[7] = 1'b0; step(3);
    chk("ovr_ack_pend", 32'(cmd_pend), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-transfer: HOLD active, command pending, byte served
    write_cmd(16'h5555);
    mcu_p2_o = 8'h60;
    step(2);
    chk("mid_sec2", 32'(bus.sec2), 32'd1);
    chk("mid_p0i", 32'(mcu_p0_i), 32'h55);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    mcu_p2_o = '0;
    mcu_p0_o = '0;
    bus.main_din = '0;
    step(3);
    rstn = 1'b1;
    step(2);
    chk_reset_vals("rst_release");

    // Write edge and acknowledge edge together
    write_cmd(16'h3333);
    chk("col_pend0", 32'(cmd_pend), 32'd1);
    mcu_p2_o[7] = 1'b1;
    step(3);
    bus.main_din = 16'h4444;
    bus.main_wr  = 1'b1;
    mcu_p2_o[7]  = 1'b0;
    step(2);
    chk("col_pend", 32'(cmd_pend), 32'd1);
    chk("col_int1n", 32'(mcu_int1n), 32'd0);
    chk("col_ovr", 32'(overrun), 32'd0);
    bus.main_wr = 1'b0;
    rd_byte(2'b10, 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
